// File: rtl/gravity_center_seq.sv
// Sequenced gravity-center engine: per-sample MAC accumulation, then a shared
// restoring divider (one quotient bit per cycle) produces rounded Xc/Yc.
// Optional macro GC_FLUSH_EN adds a 'flush' input that closes a frame early.
module gravity_center_seq #(
  parameter int N  = 5,
  parameter int XW = 8,
  parameter int WW = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef GC_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] X,
  input  logic [XW-1:0] Y,
  input  logic [WW-1:0] W,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] Xc,
  output logic [XW-1:0] Yc,
  output logic          busy
);

  localparam int CNTW = $clog2(N + 1);
  localparam int SXW  = XW + WW + $clog2(N + 1);
  localparam int SWW  = WW + $clog2(N + 1);
  localparam int DW   = SXW + 1;
  localparam int DCW  = $clog2(SXW + 2);

  typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

  state_t          state;
  logic [CNTW-1:0] count;
  logic [SXW-1:0]  sum_x, sum_y;
  logic [SWW-1:0]  sum_w;
  logic [DW-1:0]   dvd_x, dvd_y;
  logic [SWW-1:0]  rem_x, rem_y;
  logic [XW-1:0]   quo_x, quo_y;
  logic [DCW-1:0]  div_cnt;

  logic            hs;
  logic            last_smp;
  logic            close_frame;
  logic [SXW-1:0]  nsum_x, nsum_y;
  logic [SWW-1:0]  nsum_w;
  logic [DW-1:0]   dx_init, dy_init;
  logic [SWW:0]    rsh_x, rsh_y;
  logic            ge_x, ge_y;
  logic [SWW-1:0]  rnew_x, rnew_y;

  assign busy = (state != ACC);

  // Next accumulator values and frame-close decision for the current edge.
  always_comb begin
    hs       = (state == ACC) && in_valid && in_ready;
    nsum_x   = sum_x;
    nsum_y   = sum_y;
    nsum_w   = sum_w;
    if (hs) begin
      nsum_x = sum_x + SXW'(X) * SXW'(W);
      nsum_y = sum_y + SXW'(Y) * SXW'(W);
      nsum_w = sum_w + SWW'(W);
    end
    last_smp = hs && (count == CNTW'(N - 1));
`ifdef GC_FLUSH_EN
    close_frame = (state == ACC) && (last_smp || flush);
`else
    close_frame = last_smp;
`endif
    // Adding half the divisor makes the truncating divide round to nearest.
    dx_init  = {1'b0, nsum_x} + DW'(nsum_w >> 1);
    dy_init  = {1'b0, nsum_y} + DW'(nsum_w >> 1);
  end

  // One restoring-division step per axis; remainder always stays below sum_w.
  always_comb begin
    rsh_x  = {rem_x, dvd_x[DW-1]};
    rsh_y  = {rem_y, dvd_y[DW-1]};
    ge_x   = (rsh_x >= {1'b0, sum_w});
    ge_y   = (rsh_y >= {1'b0, sum_w});
    rnew_x = ge_x ? (rsh_x[SWW-1:0] - sum_w) : rsh_x[SWW-1:0];
    rnew_y = ge_y ? (rsh_y[SWW-1:0] - sum_w) : rsh_y[SWW-1:0];
  end

  // Controller: accumulate, divide, hold result until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      count     <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
      sum_w     <= '0;
      dvd_x     <= '0;
      dvd_y     <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      quo_x     <= '0;
      quo_y     <= '0;
      div_cnt   <= '0;
      Xc        <= '0;
      Yc        <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          sum_x <= nsum_x;
          sum_y <= nsum_y;
          sum_w <= nsum_w;
          if (close_frame) begin
            count    <= '0;
            in_ready <= 1'b0;
            if (nsum_w == '0) begin
              // Zero total weight: result is forced to 0 on the next edge.
              state <= OUT;
            end else begin
              state   <= DIV;
              dvd_x   <= dx_init;
              dvd_y   <= dy_init;
              rem_x   <= '0;
              rem_y   <= '0;
              quo_x   <= '0;
              quo_y   <= '0;
              div_cnt <= '0;
            end
          end else begin
            in_ready <= 1'b1;
            if (hs) count <= count + 1'b1;
          end
        end
        DIV: begin
          if (div_cnt == DCW'(SXW + 1)) begin
            // Upper quotient bits are zero since the result is a weighted mean.
            Xc        <= quo_x;
            Yc        <= quo_y;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            dvd_x   <= {dvd_x[DW-2:0], 1'b0};
            dvd_y   <= {dvd_y[DW-2:0], 1'b0};
            rem_x   <= rnew_x;
            rem_y   <= rnew_y;
            quo_x   <= {quo_x[XW-2:0], ge_x};
            quo_y   <= {quo_y[XW-2:0], ge_y};
            div_cnt <= div_cnt + 1'b1;
          end
        end
        OUT: begin
          if (!out_valid) begin
            Xc        <= '0;
            Yc        <= '0;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            sum_x     <= '0;
            sum_y     <= '0;
            sum_w     <= '0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_gravity_center_seq.sv
// Directed bench for gravity_center_seq: frame results, latency, zero weight,
// output stall, mid-divide reset and (with GC_FLUSH_EN) early frame close.
module tb_gravity_center_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] X = '0;
  logic [7:0] Y = '0;
  logic [3:0] W = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] Xc;
  logic [7:0] Yc;
  logic       busy;
`ifdef GC_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  int lat      = 0;
  bit saw_rdy;
  bit saw_ov;

  gravity_center_seq dut (
    .clk      (clk),
    .rst      (rst),
`ifdef GC_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .Y        (Y),
    .W        (W),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Xc       (Xc),
    .Yc       (Yc),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until the handshake edge has passed.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [3:0] w);
    int k;
    X = x; Y = y; W = w;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    tick();
    hs_cyc = cyc;
  endtask

  task automatic send_frame1();
    send(8'd10, 8'd20, 4'd1);
    send(8'd20, 8'd40, 4'd1);
    send(8'd30, 8'd60, 4'd2);
    send(8'd0,  8'd0,  4'd0);
    send(8'd40, 8'd80, 4'd4);
  endtask

  // Wait (bounded) for out_valid, noting whether in_ready ever rose meanwhile.
  task automatic wait_result();
    int k;
    saw_rdy = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      if (in_ready) saw_rdy = 1'b1;
      tick();
      k++;
    end
    lat = cyc - hs_cyc;
    chk("out_valid_rise", out_valid, 1);
  endtask

  // Accept the result (out_ready assumed high) and check return to ACC.
  task automatic consume(input string tag);
    tick();
    in_valid = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    // Reset values while rst is held.
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xc", Xc, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // Frame 1 with in_valid held high across the divide.
    send_frame1();
    chk("f1_busy_div", busy, 1);
    chk("f1_in_ready_div", in_ready, 0);
    wait_result();
    chk("f1_latency", lat, 17);
    chk("f1_xc", Xc, 31);
    chk("f1_yc", Yc, 63);
    chk("f1_no_ready_in_div", saw_rdy, 0);
    consume("f1");

    // All-zero weights: divide skipped, result one edge after last handshake.
    for (int i = 0; i < 5; i++) send(8'(i * 40 + 7), 8'(200 - i), 4'd0);
    wait_result();
    chk("zw_latency", lat, 1);
    chk("zw_xc", Xc, 0);
    chk("zw_yc", Yc, 0);
    consume("zw");

    // Full-scale frame with a 5-cycle output stall.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'd255, 8'd255, 4'd15);
    wait_result();
    chk("max_latency", lat, 17);
    chk("max_xc", Xc, 255);
    chk("max_yc", Yc, 255);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      X = 8'(i * 13); Y = 8'(i * 7); W = 4'd9;
      tick();
      chk("stall_ov", out_valid, 1);
      chk("stall_xc", Xc, 255);
      chk("stall_yc", Yc, 255);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    consume("stall");

    // Next frame must not see the previous sums.
    send_frame1();
    wait_result();
    chk("f2_xc", Xc, 31);
    chk("f2_yc", Yc, 63);
    consume("f2");

    // Reset in the middle of the divide.
    send_frame1();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_xc", Xc, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    saw_ov = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) saw_ov = 1'b1;
    end
    chk("post_rst_no_ov", saw_ov, 0);
    chk("post_rst_xc", Xc, 0);
    chk("post_rst_yc", Yc, 0);
    send_frame1();
    wait_result();
    chk("f3_latency", lat, 17);
    chk("f3_xc", Xc, 31);
    chk("f3_yc", Yc, 63);
    consume("f3");

`ifdef GC_FLUSH_EN
    // Early close including the sample handshaking on the flush edge.
    send(8'd100, 8'd50, 4'd3);
    X = 8'd200; Y = 8'd150; W = 4'd1;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    hs_cyc = cyc;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_busy", busy, 1);
    wait_result();
    chk("fl_latency", lat, 17);
    chk("fl_xc", Xc, 125);
    chk("fl_yc", Yc, 75);
    consume("fl");

    // Flush of an empty frame.
    flush = 1'b1;
    tick();
    hs_cyc = cyc;
    flush = 1'b0;
    wait_result();
    chk("fl0_latency", lat, 1);
    chk("fl0_xc", Xc, 0);
    chk("fl0_yc", Yc, 0);
    consume("fl0");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
